aurora_rx_deframer: RTL and testbench
=====================================

Name: aurora_rx_deframer

Overview:
- Drains the RX FIFO that the Aurora link controller fills with received 32-bit words (user_clk domain).
- Parses the word stream into framed packets: header, payload, checksum trailer.
- Delivers payload words on a valid/ready stream with sof/eof markers, and reports per-packet checksum status and error counters.
- Sits between the Aurora RX FIFO read port and the DSP-side packet consumer.

Parameters:
- MAGIC, 16'hBE11, required value of header bits [31:16].
- MAX_LEN, 1024, largest legal payload length in words.
- TIMEOUT, 4095, idle cycles allowed mid-packet before abort.
- CNT_W, 16, width of the status counters.

Ports:
- user_clk  in  1  clock, Aurora user clock.
- rst  in  1  synchronous active-high reset.
- fifo_dat_i  in  32  RX FIFO read data, valid one cycle after fifo_rd_o (standard, not FWFT).
- fifo_empty_i  in  1  RX FIFO empty.
- fifo_rd_o  out  1  RX FIFO read strobe.
- m_dat  out  32  payload word.
- m_valid  out  1  payload word valid.
- m_ready  in  1  consumer accepts the word.
- m_sof  out  1  first payload word of a packet, qualified by m_valid.
- m_eof  out  1  last payload word of a packet, qualified by m_valid.
- pkt_done  out  1  one-cycle pulse when a trailer is consumed.
- pkt_ok  out  1  checksum matched; valid with pkt_done.
- pkt_abort  out  1  one-cycle pulse on a mid-packet timeout.
- busy  out  1  state is not HDR, or a word is held.
- pkt_cnt  out  CNT_W  good packets.
- sync_err_cnt  out  CNT_W  words discarded as a bad header or bad length.
- chk_err_cnt  out  CNT_W  checksum mismatches.

Behaviour:
- Reset: all outputs 0, counters 0, skid buffer empty, in-flight flag 0, state HDR.
- Frame format:
  - Header: [31:16]=MAGIC, [15:0]=N, with 1<=N<=MAX_LEN.
  - Then N payload words.
  - Then the trailer: the sum of the N payload words modulo 2^32.
- Read pipeline: a 2-entry skid buffer plus a one-bit in-flight flag (fifo_rd_o was asserted in the previous cycle).
  - fifo_rd_o = !fifo_empty_i && (occ + inflight - pop) < 2.
  - pop = the head word is consumed this cycle.
  - Returned data is written to the skid buffer on the cycle after fifo_rd_o.
  - The buffer never overflows; a bench assertion checks that occupancy stays <= 2.
- Sustained throughput: 1 word per cycle when the FIFO is non-empty and m_ready is held high.
- State machine:
  - HDR: consumes the head word internally.
    - Good magic and legal N: latch N, clear the sum, go to PAY; the next payload word carries m_sof.
    - Bad magic, N=0, or N>MAX_LEN: discard the word, increment sync_err_cnt (saturating), stay in HDR. This is the hunt for the next header.
  - PAY: m_valid = occ>0; m_dat = head word.
    - On m_valid && m_ready: add the word to the sum and decrement the remaining count.
    - m_eof is asserted when the remaining count = 1. After that word, go to TRL.
    - m_sof and m_eof are both high when N=1.
  - TRL: consume the head word internally.
    - pkt_done=1 and pkt_ok=(word==sum) in the following cycle.
    - On a match, increment pkt_cnt; otherwise increment chk_err_cnt.
    - Go to HDR.
- m_valid stays low in HDR and TRL. While m_valid is high and m_ready is low, m_dat, m_sof and m_eof hold stable.
- Timeout:
  - In PAY or TRL, an idle counter counts cycles with occ=0 and inflight=0. It resets on any consumed word.
  - When the counter reaches TIMEOUT: pulse pkt_abort, go to HDR. No eof is emitted, and no counter other than sync_err_cnt changes; sync_err_cnt does not change either.
  - Stall by m_ready low never times out.
- Counters saturate at all-ones.
- rst mid-packet: immediate return to reset values. A read issued in the cycle before rst is dropped, and its data is ignored.
- Arithmetic: the sum is 32-bit with wrap-around. N is compared as unsigned 16-bit.

Test Plan:
- Header 0xBE110003, payload 1,2,3, trailer 6, FIFO always non-empty, m_ready=1:
  - 3 beats, sof on the first and eof on the third.
  - pkt_done with pkt_ok=1; pkt_cnt=1.
  - fifo_rd_o high on consecutive cycles, i.e. one word per cycle sustained.
- Same packet with trailer 7 -> pkt_ok=0, chk_err_cnt=1, pkt_cnt=0.
- Words 0x12345678, 0xBE110000, 0xBE110401, then a good N=1 packet (payload 0xFFFFFFFF, trailer 0xFFFFFFFF):
  - sync_err_cnt=3.
  - A single beat with sof=eof=1; pkt_ok=1.
- Payload 0x80000000 and 0x80000000, trailer 0 -> wrap-around sum matches, pkt_ok=1.
- m_ready toggled randomly 50% during an N=16 packet:
  - All 16 words delivered in order with no loss or duplication.
  - Skid occupancy stays <= 2; no timeout.
- Header N=4, 2 payload words, then FIFO empty for 4095 cycles -> pkt_abort pulse, state HDR; a following good packet is received correctly.
- rst asserted mid-PAY -> outputs and counters 0 next cycle, fifo_rd_o low during rst.

Source files
------------

// File: rtl/aurora_rx_deframer_if.sv
// Payload stream from the deframer to the DSP-side packet consumer.
// dat/sof/eof are qualified by valid; a beat transfers on valid && ready.
interface aurora_rx_deframer_if;
  logic [31:0] dat;
  logic        valid;
  logic        ready;
  logic        sof;
  logic        eof;

  modport master (output dat, output valid, output sof, output eof, input ready);
  modport slave  (input dat, input valid, input sof, input eof, output ready);
endinterface

// File: rtl/aurora_rx_deframer.sv
// Aurora RX deframer: drains the RX FIFO (standard read, data one cycle
// after the strobe) through a 2-entry skid buffer, parses header/payload/
// checksum-trailer frames and streams the payload with sof/eof markers.
//
// state | meaning
// HDR   | consume head word as a header; bad words are discarded (hunt)
// PAY   | present head word on the stream, count down the payload length
// TRL   | consume head word as the checksum trailer, report status
module aurora_rx_deframer #(
  parameter logic [15:0] MAGIC   = 16'hBE11,
  parameter int          MAX_LEN = 1024,
  parameter int          TIMEOUT = 4095,
  parameter int          CNT_W   = 16
) (
  input  logic                 user_clk,
  input  logic                 rst,
  input  logic [31:0]          fifo_dat_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_o,
  aurora_rx_deframer_if.master m,
  output logic                 pkt_done,
  output logic                 pkt_ok,
  output logic                 pkt_abort,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     sync_err_cnt,
  output logic [CNT_W-1:0]     chk_err_cnt
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {HDR, PAY, TRL} state_t;

  state_t            state_q, state_d;
  logic [31:0]       skid_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        occ_q;
  logic              inflight_q;
  logic [31:0]       head;
  logic              has_word;
  logic              pop;
  logic [2:0]        level;
  logic [15:0]       rem_q;
  logic              first_q;
  logic [31:0]       sum_q;
  logic [IDLE_W-1:0] idle_q;
  logic              idle;
  logic              timeout;
  logic              hdr_ok;

  assign head     = skid_q[rd_ptr_q];
  assign has_word = (occ_q != 2'd0);
  assign hdr_ok   = (head[31:16] == MAGIC) && (head[15:0] != 16'd0) &&
                    (head[15:0] <= 16'(MAX_LEN));

  // Occupancy after this cycle's pop plus the word already on its way back.
  assign level     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_o = !rst && !fifo_empty_i && (level < 3'd2);

  // Idle means nothing buffered and nothing in flight; m.ready stalls never count.
  assign idle    = !has_word && !inflight_q;
  assign timeout = (state_q != HDR) && idle && (idle_q == '0);

  assign m.dat = head;
  assign m.sof = m.valid && first_q;
  assign m.eof = m.valid && (rem_q == 16'd1);
  assign busy  = (state_q != HDR) || has_word;

  // State register.
  always_ff @(posedge user_clk) begin
    if (rst) state_q <= HDR;
    else     state_q <= state_d;
  end

  // Next state, head-word consumption and stream valid.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    m.valid = 1'b0;
    case (state_q)
      HDR: begin
        if (has_word) begin
          pop = 1'b1;
          if (hdr_ok) state_d = PAY;
        end
      end
      PAY: begin
        m.valid = has_word;
        pop     = has_word && m.ready;
        if (pop && (rem_q == 16'd1)) state_d = TRL;
        else if (timeout)            state_d = HDR;
      end
      TRL: begin
        if (has_word) begin
          pop     = 1'b1;
          state_d = HDR;
        end else if (timeout) begin
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  // Skid buffer: returned FIFO data lands in the free slot, pops advance the head.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_o;
      if (inflight_q) begin
        skid_q[wr_ptr_q] <= fifo_dat_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // Packet bookkeeping: length, checksum, idle timer, status pulses and counters.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      rem_q        <= '0;
      first_q      <= 1'b0;
      sum_q        <= '0;
      idle_q       <= IDLE_W'(TIMEOUT - 1);
      pkt_done     <= 1'b0;
      pkt_ok       <= 1'b0;
      pkt_abort    <= 1'b0;
      pkt_cnt      <= '0;
      sync_err_cnt <= '0;
      chk_err_cnt  <= '0;
    end else begin
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_abort <= timeout;
      if (state_q == HDR && pop) begin
        if (hdr_ok) begin
          rem_q   <= head[15:0];
          sum_q   <= '0;
          first_q <= 1'b1;
        end else if (sync_err_cnt != '1) begin
          sync_err_cnt <= sync_err_cnt + CNT_W'(1);
        end
      end
      if (state_q == PAY && pop) begin
        sum_q   <= sum_q + head;
        rem_q   <= rem_q - 16'd1;
        first_q <= 1'b0;
      end
      if (state_q == TRL && pop) begin
        pkt_done <= 1'b1;
        pkt_ok   <= (head == sum_q);
        if (head == sum_q) begin
          if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
        end else begin
          if (chk_err_cnt != '1) chk_err_cnt <= chk_err_cnt + CNT_W'(1);
        end
      end
      if (state_q == HDR || pop)      idle_q <= IDLE_W'(TIMEOUT - 1);
      else if (idle && idle_q != '0)  idle_q <= idle_q - IDLE_W'(1);
    end
  end

endmodule

// File: tb/tb_aurora_rx_deframer.sv
// Bench for aurora_rx_deframer: a queue-backed RX FIFO model, frame-level
// expectations pushed at stimulus time, and a negedge monitor that pops them.
module tb_aurora_rx_deframer;
  localparam logic [15:0] MAGIC   = 16'hBE11;
  localparam int          MAX_LEN = 1024;
  localparam int          TIMEOUT = 4095;

  typedef struct { logic [31:0] dat; logic sof; logic eof; } beat_t;

  logic        user_clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fifo_dat = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic        pkt_done, pkt_ok, pkt_abort, busy;
  logic [15:0] pkt_cnt, sync_err_cnt, chk_err_cnt;

  aurora_rx_deframer_if m_if ();

  aurora_rx_deframer dut (
    .user_clk     (user_clk),
    .rst          (rst),
    .fifo_dat_i   (fifo_dat),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_o    (fifo_rd),
    .m            (m_if),
    .pkt_done     (pkt_done),
    .pkt_ok       (pkt_ok),
    .pkt_abort    (pkt_abort),
    .busy         (busy),
    .pkt_cnt      (pkt_cnt),
    .sync_err_cnt (sync_err_cnt),
    .chk_err_cnt  (chk_err_cnt)
  );

  always #5 user_clk = ~user_clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] fifo_q [$];
  logic [31:0] pay_q [$];
  beat_t       beat_q [$];
  int          ev_q [$];   // 0 = done/bad, 1 = done/ok, 2 = abort
  int exp_pkt = 0, exp_sync = 0, exp_chk = 0;
  bit gaps_on = 0, rand_ready = 0;
  int cyc = 0, beats_seen = 0, last_beat_cyc = 0, abort_cyc = 0;
  int rd_run = 0, rd_run_max = 0, occ_max = 0;
  bit hold_v = 0;
  beat_t hold_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RX FIFO model: standard read, data presented one cycle after the strobe.
  initial begin
    bit rd;
    int gap;
    gap = 0;
    forever begin
      @(negedge user_clk);
      rd = fifo_rd;
      @(posedge user_clk);
      #1;
      if (rd) begin
        if (fifo_q.size() > 0) fifo_dat = fifo_q.pop_front();
        else check("fifo_underflow", 1, 0);
      end
      if (gaps_on && gap == 0 && $urandom_range(0, 9) == 0) gap = $urandom_range(1, 12);
      if (gap > 0) gap--;
      fifo_empty  = (fifo_q.size() == 0) || (gap > 0);
      m_if.ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expected beats and packet events as the DUT presents them.
  always @(negedge user_clk) begin
    beat_t e;
    int ev;
    cyc++;
    if (rst) begin
      hold_v = 0;
      rd_run = 0;
    end else begin
      if (dut.occ_q > 2'd2) check("skid_occ", 64'(dut.occ_q), 2);
      if (int'(dut.occ_q) > occ_max) occ_max = int'(dut.occ_q);
      if (fifo_rd) begin
        rd_run++;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
      end else rd_run = 0;
      if (hold_v) begin
        check("hold_valid", m_if.valid, 1);
        check("hold_beat", {m_if.dat, m_if.sof, m_if.eof}, {hold_b.dat, hold_b.sof, hold_b.eof});
      end
      hold_v = m_if.valid && !m_if.ready;
      hold_b.dat = m_if.dat; hold_b.sof = m_if.sof; hold_b.eof = m_if.eof;
      if (m_if.valid && m_if.ready) begin
        beats_seen++;
        last_beat_cyc = cyc;
        if (beat_q.size() == 0) check("unexpected_beat", m_if.dat, 0);
        else begin
          e = beat_q.pop_front();
          check("beat_dat", m_if.dat, e.dat);
          check("beat_sof_eof", {m_if.sof, m_if.eof}, {e.sof, e.eof});
        end
      end
      if (pkt_done && pkt_abort) check("done_and_abort", 1, 0);
      if (pkt_done || pkt_abort) begin
        if (pkt_abort) abort_cyc = cyc;
        if (ev_q.size() == 0) check("unexpected_event", pkt_abort ? 2 : 64'(pkt_ok), 9);
        else begin
          ev = ev_q.pop_front();
          check("pkt_status", pkt_abort ? 2 : 64'(pkt_ok), 64'(ev));
        end
      end
    end
  end

  // One frame from pay_q; keep < size truncates it (no trailer, abort expected).
  task automatic send_frame(input bit corrupt, input int keep);
    logic [31:0] sum;
    int n;
    beat_t b;
    sum = '0;
    n = pay_q.size();
    fifo_q.push_back({MAGIC, 16'(n)});
    for (int i = 0; i < keep; i++) begin
      fifo_q.push_back(pay_q[i]);
      sum = sum + pay_q[i];
      b.dat = pay_q[i]; b.sof = (i == 0); b.eof = (i == n - 1);
      beat_q.push_back(b);
    end
    if (keep == n) begin
      fifo_q.push_back(corrupt ? (sum ^ (32'd1 << $urandom_range(0, 31))) : sum);
      ev_q.push_back(corrupt ? 0 : 1);
      if (corrupt) exp_chk++; else exp_pkt++;
    end else ev_q.push_back(2);
  endtask

  task automatic send_junk(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_sync++;
  endtask

  task automatic rand_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back($urandom);
  endtask

  task automatic step();
    @(posedge user_clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_q.delete(); beat_q.delete(); ev_q.delete();
    exp_pkt = 0; exp_sync = 0; exp_chk = 0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while ((fifo_q.size() != 0 || beat_q.size() != 0 || ev_q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) check({name, "_drain_timeout"}, 64'(beat_q.size() + ev_q.size()), 0);
    repeat (4) step();
  endtask

  task automatic check_counters(input string name);
    check({name, "_pkt_cnt"}, pkt_cnt, 64'(exp_pkt));
    check({name, "_sync_err_cnt"}, sync_err_cnt, 64'(exp_sync));
    check({name, "_chk_err_cnt"}, chk_err_cnt, 64'(exp_chk));
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int b0, c, kind;
    logic [31:0] w;
    m_if.ready = 1'b1;
    repeat (3) step();
    check("rst_outputs", {fifo_rd, m_if.valid, m_if.sof, m_if.eof, pkt_done, pkt_ok, pkt_abort, busy}, 0);
    check("rst_counters", {pkt_cnt, sync_err_cnt, chk_err_cnt, m_if.dat}, 0);
    rst = 1'b0;

    // 1,2,3 with trailer 6, back-to-back reads
    do_reset();
    rd_run_max = 0;
    pay_q = '{32'd1, 32'd2, 32'd3};
    send_frame(0, 3);
    drain("t1", 200);
    check("t1_read_run", 64'(rd_run_max), 5);
    check_counters("t1");

    // same frame, trailer 7
    do_reset();
    fifo_q.push_back(32'hBE110003);
    fifo_q.push_back(32'd1); fifo_q.push_back(32'd2); fifo_q.push_back(32'd3);
    fifo_q.push_back(32'd7);
    hold_b.dat = 1; hold_b.sof = 1; hold_b.eof = 0; beat_q.push_back(hold_b);
    hold_b.dat = 2; hold_b.sof = 0; hold_b.eof = 0; beat_q.push_back(hold_b);
    hold_b.dat = 3; hold_b.sof = 0; hold_b.eof = 1; beat_q.push_back(hold_b);
    ev_q.push_back(0);
    exp_chk = 1;
    drain("t2", 200);
    check_counters("t2");

    // three rejected headers, then an N=1 frame
    do_reset();
    send_junk(32'h12345678);
    send_junk(32'hBE110000);
    send_junk(32'hBE110401);
    pay_q = '{32'hFFFFFFFF};
    send_frame(0, 1);
    drain("t3", 200);
    check_counters("t3");

    // wrap-around checksum
    do_reset();
    pay_q = '{32'h80000000, 32'h80000000};
    send_frame(0, 2);
    drain("t4", 200);
    check_counters("t4");

    // N=16 with random back-pressure
    do_reset();
    rand_ready = 1;
    rand_payload(16);
    send_frame(0, 16);
    drain("t5", 1000);
    check_counters("t5");
    rand_ready = 0;

    // truncated frame times out, then a good frame
    do_reset();
    rand_payload(4);
    send_frame(0, 2);
    drain("t6a", 6000);
    c = abort_cyc - last_beat_cyc;
    check("t6_abort_latency_in_window", 64'((c >= TIMEOUT - 2) && (c <= TIMEOUT + 6)), 1);
    check_counters("t6a");
    rand_payload(3);
    send_frame(0, 3);
    drain("t6b", 200);
    check_counters("t6b");

    // reset in the middle of a payload
    do_reset();
    pay_q = '{32'hA5A5A5A5};
    send_frame(0, 1);
    send_junk(32'h00000000);
    rand_payload(8);
    send_frame(0, 8);
    b0 = beats_seen;
    c = 0;
    while (beats_seen < b0 + 4 && c < 200) begin step(); c++; end
    check("t7_reached_pay", 64'(c < 200), 1);
    check("t7_pre_pkt_cnt", pkt_cnt, 1);
    check("t7_pre_sync_cnt", sync_err_cnt, 1);
    rst = 1'b1;
    fifo_q.delete(); beat_q.delete(); ev_q.delete();
    exp_pkt = 0; exp_sync = 0; exp_chk = 0;
    @(negedge user_clk);
    check("t7_rd_in_rst", fifo_rd, 0);
    @(posedge user_clk);
    #1;
    check("t7_outputs", {m_if.valid, m_if.sof, m_if.eof, pkt_done, pkt_ok, pkt_abort, busy}, 0);
    check("t7_counters", {pkt_cnt, sync_err_cnt, chk_err_cnt}, 0);
    step();
    rst = 1'b0;
    rand_payload(5);
    send_frame(0, 5);
    drain("t7", 200);
    check_counters("t7");

    // largest legal length
    do_reset();
    rand_ready = 1;
    rand_payload(MAX_LEN);
    send_frame(0, MAX_LEN);
    drain("t8", 6000);
    check_counters("t8");

    // random mix with FIFO gaps and back-pressure
    gaps_on = 1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if (kind >= 8) begin
        for (int j = 0; j < $urandom_range(1, 3); j++) begin
          case ($urandom_range(0, 2))
            0: begin
              w = $urandom;
              if (w[31:16] == MAGIC) w[31] = ~w[31];
            end
            1: w = {MAGIC, 16'd0};
            default: w = {MAGIC, 16'(MAX_LEN + 1 + $urandom_range(0, 60000))};
          endcase
          send_junk(w);
        end
      end
      rand_payload($urandom_range(1, 12));
      send_frame(kind == 6 || kind == 7, pay_q.size());
      if (f % 10 == 9) drain("rnd", 3000);
    end
    drain("rnd_end", 3000);
    check_counters("rnd");
    check("occ_max", 64'(occ_max <= 2), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion earlier", cyc);
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
